dequantize_stream: RTL and testbench
====================================

Name: dequantize_stream

Overview:
JPEG decode-side inverse of the quantizer stage. Accepts quantized integer coefficients one per beat in natural row-major 8x8 order. Multiplies each coefficient by its standard quantization step (luma or chroma). Emits Q16.16 coefficients toward the IDCT, with a 2-stage stallable pipeline and a valid/ready handshake on both sides.

Parameters:
COEF_W, 12, signed quantized-coefficient input width (two's complement)
FRAC_BITS, 16, fractional bits of the output fixed-point format
USE_LUMA, 1, table applied after reset until the first tbl_sel sample (1 = luma, 0 = chroma)

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_coef  input  COEF_W  signed quantized coefficient
in_last  input  1  upstream marks the final beat of a block
tbl_sel  input  1  table select (1 luma, 0 chroma); sampled only on an accepted beat at index 0
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts output
out_coef  output  32  signed Q16.16 dequantized coefficient
out_last  output  1  marks output of index 63
out_index  output  6  natural-order index of out_coef
blk_err  output  1  sticky: in_last seen at index != 63, or index 63 without in_last

Behaviour:
- Reset (async assert, sync release): idx=0, tbl latched = USE_LUMA, both stage-valid flags 0, out_valid=0, out_coef=0, out_last=0, out_index=0, blk_err=0.
- Tables: 8-bit constants, standard JPEG Annex K, row-major.
  - luma[0..7]=16,11,10,16,24,40,51,61; luma[56..63]=72,92,95,98,112,100,103,99.
  - chroma[0..7]=17,18,24,47,99,99,99,99; chroma[32..63]=99.
- Handshake: beat accepted when in_valid && in_ready. Output consumed when out_valid && out_ready. Data is held stable while out_valid && !out_ready.
- Pipeline:
  - S1 registers product = in_coef * q[idx], signed COEF_W x unsigned 8, plus idx and last.
  - S2 registers the saturated, shifted result.
  - A stage advances when it is empty or its successor advances.
  - in_ready = !s1_valid || s1_advance, so it is combinational from out_ready (no bubble at full throughput).
  - Latency: 2 cycles from acceptance to out_valid. Throughput: 1 beat/cycle when out_ready is held high.
- Arithmetic:
  - Compute full = product << FRAC_BITS, sign-extended to COEF_W+8+FRAC_BITS bits.
  - If full > 0x7FFFFFFF, out = 0x7FFFFFFF; if full < -0x80000000, out = 0x80000000; else out = full[31:0].
  - Zero coefficient gives 0.
- Index counter:
  - idx increments on each accepted beat and wraps 63->0.
  - At idx==0 an accepted beat latches tbl_sel for the whole block.
  - out_last = (out_index==63).
- Framing error:
  - in_last accepted at idx!=63: blk_err set; idx forced to 0 after that beat (resync); the beat is still output with its real index.
  - idx 63 accepted without in_last: blk_err set; idx wraps normally.
  - blk_err clears only on reset.
- Simultaneous accept and consume in one cycle: both occur, no loss or duplication.
- Reset mid-block: in-flight beats are discarded, idx returns to 0, out_valid drops immediately (async).

Test Plan:
- Luma, tbl_sel=1, in_coef=3 at idx0 then -2 at idx1, out_ready=1 -> out_coef 0x00300000 then 0xFFEA0000, out_index 0 then 1, each 2 cycles after acceptance.
- Full 64-beat chroma block (tbl_sel=0 at idx0, toggled to 1 mid-block), all coefficients=1, in_last on beat 63 -> outputs 17<<16, 18<<16, 24<<16, 47<<16, then 99<<16 for all remaining; out_last only on index 63; blk_err=0; 64 outputs in 66 cycles.
- Saturation, luma idx63 (q=99): in_coef=2047 -> 0x7FFFFFFF; in_coef=-2048 -> 0x80000000.
- Backpressure: stream 10 beats while out_ready toggles 1,0,0,1 repeating -> all 10 outputs appear in order, values held during stalls, in_ready low only while both stages are full and stalled.
- in_last asserted at idx 5 -> blk_err=1 from the next cycle; the following beat is output with out_index 0; a following clean 64-beat block produces correct data with blk_err still 1.
- rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately; after release the first accepted beat yields out_index 0 using the USE_LUMA table.

Source files
------------

// File: rtl/dequantize_stream.sv
// ---------------------------------------------------------------------------
// dequantize_stream
//
// Decode-side JPEG dequantizer. Quantized coefficients arrive one per beat in
// natural row-major 8x8 order. Each is multiplied by the Annex K quantization
// step for its position (luma or chroma table, chosen per block) and emitted
// as a saturated signed Q16.16 value through a 2-stage stallable pipeline.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (combinational from out_ready)
//   in_coef    signed quantized coefficient, COEF_W bits
//   in_last    upstream marks the final beat of a block
//   tbl_sel    table select (1 luma, 0 chroma), sampled on an accepted idx-0 beat
//   out_valid  output beat valid
//   out_ready  downstream accepts output
//   out_coef   signed Q16.16 dequantized coefficient
//   out_last   high when out_index is 63
//   out_index  natural-order index of out_coef
//   blk_err    sticky framing error (in_last and index 63 disagree)
// ---------------------------------------------------------------------------
module dequantize_stream #(
    parameter int COEF_W    = 12,
    parameter int FRAC_BITS = 16,
    parameter bit USE_LUMA  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_coef,
    input  logic                     in_last,
    input  logic                     tbl_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [31:0]       out_coef,
    output logic                     out_last,
    output logic [5:0]               out_index,
    output logic                     blk_err
);

    // Signed COEF_W x unsigned 8-bit step always fits in COEF_W+8 signed bits.
    localparam int PROD_W = COEF_W + 8;
    // The shifted product must be wider than 32 bits for the overflow test below.
    localparam int FULL_W = PROD_W + FRAC_BITS;

    localparam logic [7:0] LUMA_Q [64] = '{
        8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
        8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
        8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
        8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
        8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
        8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
        8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
        8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
    };

    localparam logic [7:0] CHROMA_Q [64] = '{
        8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
    };

    function automatic logic [7:0] q_step(input logic luma, input logic [5:0] i);
        return luma ? LUMA_Q[i] : CHROMA_Q[i];
    endfunction

    // Shift the product into Q16.16 and clamp to the signed 32-bit range.
    // Overflow is present when the bits above bit 31 are not all copies of
    // the sign bit.
    function automatic logic signed [31:0] sat_q16(input logic signed [PROD_W-1:0] p);
        logic [FULL_W-1:0] full;
        full = {p, {FRAC_BITS{1'b0}}};
        if (!full[FULL_W-1] && (|full[FULL_W-2:31]))
            return 32'sh7FFFFFFF;
        else if (full[FULL_W-1] && !(&full[FULL_W-2:31]))
            return 32'sh80000000;
        else
            return signed'(full[31:0]);
    endfunction

    logic [5:0]               idx;
    logic                     tbl_q;
    logic                     vld_p1;
    logic                     vld_p2;
    logic signed [PROD_W-1:0] prod_p1;
    logic [5:0]               idx_p1;

    logic                     s1_take;
    logic                     s2_take;
    logic                     accept;
    logic                     cur_luma;
    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] q_ext;
    logic signed [PROD_W-1:0] prod;

    // A stage can load when it is empty or its content moves on this cycle.
    always_comb begin
        s2_take  = !vld_p2 || out_ready;
        s1_take  = !vld_p1 || s2_take;
        accept   = in_valid && s1_take;
        // The idx-0 beat uses tbl_sel directly; later beats use the latched choice.
        cur_luma = (idx == 6'd0) ? tbl_sel : tbl_q;
        coef_ext = PROD_W'(in_coef);
        q_ext    = signed'(PROD_W'(q_step(cur_luma, idx)));
        prod     = coef_ext * q_ext;
    end

    assign in_ready  = s1_take;
    assign out_valid = vld_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            tbl_q   <= USE_LUMA;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            blk_err <= 1'b0;
        end else begin
            if (s1_take)
                vld_p1 <= accept;
            if (s2_take)
                vld_p2 <= vld_p1;
            if (accept) begin
                if (idx == 6'd0)
                    tbl_q <= tbl_sel;
                if (in_last && (idx != 6'd63)) begin
                    // Early block end: flag it and resync so the next beat starts a block.
                    blk_err <= 1'b1;
                    idx     <= '0;
                end else begin
                    if (!in_last && (idx == 6'd63))
                        blk_err <= 1'b1;
                    idx <= idx + 6'd1;
                end
            end
        end
    end

    // ---- Stage 1: raw product and its index ----
    always_ff @(posedge clk) begin
        if (accept) begin
            prod_p1 <= prod;
            idx_p1  <= idx;
        end
    end

    // ---- Stage 2: Q16.16 saturated result ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_coef  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else if (s2_take && vld_p1) begin
            out_coef  <= sat_q16(prod_p1);
            out_index <= idx_p1;
            out_last  <= (idx_p1 == 6'd63);
        end
    end

endmodule

// File: tb/tb_dequantize_stream.sv
module tb_dequantize_stream;

    localparam int COEF_W = 12;

    localparam int LQ [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    localparam int CQ [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [COEF_W-1:0] in_coef = '0;
    logic                     in_last = 1'b0;
    logic                     tbl_sel = 1'b1;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [31:0]       out_coef;
    logic                     out_last;
    logic [5:0]               out_index;
    logic                     blk_err;

    dequantize_stream #(
        .COEF_W    (COEF_W),
        .FRAC_BITS (16),
        .USE_LUMA  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .in_last   (in_last),
        .tbl_sel   (tbl_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_last  (out_last),
        .out_index (out_index),
        .blk_err   (blk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] coef;
        logic [5:0]  idx;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_idx = 0;
    bit          m_tbl = 1'b1;
    bit          lat_chk = 1'b0;
    int          last_cons = 0;
    int          n_cons = 0;
    bit          held = 1'b0;
    logic [31:0] held_coef;
    logic [5:0]  held_idx;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_val(input int coef, input int q);
        longint p;
        p = longint'(coef) * longint'(q) * 64'sd65536;
        if (p > 64'sd2147483647)
            return 32'h7FFFFFFF;
        if (p < -64'sd2147483648)
            return 32'h80000000;
        return p[31:0];
    endfunction

    // Output monitor: handshake rule, stall stability and scoreboard ordering.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            checks++;
            if (in_ready !== !(sb.size() == 2 && !out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b, want %b (occupancy %0d, out_ready %b)",
                         in_ready, !(sb.size() == 2 && !out_ready), sb.size(), out_ready);
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_coef !== held_coef || out_index !== held_idx) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h idx %0d, want v=1 %h idx %0d",
                             out_valid, out_coef, out_index, held_coef, held_idx);
                end
            end
            if (out_valid && !out_ready) begin
                held      = 1'b1;
                held_coef = out_coef;
                held_idx  = out_index;
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got %h idx %0d, want no output", out_coef, out_index);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_coef !== e.coef || out_index !== e.idx || out_last !== (e.idx == 6'd63)) begin
                        errors++;
                        $display("FAIL out_beat: got %h idx %0d last %b, want %h idx %0d last %b",
                                 out_coef, out_index, out_last, e.coef, e.idx, (e.idx == 6'd63));
                    end
                    if (e.lat) begin
                        checks++;
                        if (cyc - e.acc != 2) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles, want 2", cyc - e.acc);
                        end
                    end
                end
                last_cons = cyc;
                n_cons++;
            end
        end
    end

    task automatic send(input int coef, input bit last, input bit tsel);
        int   guard;
        bit   ok;
        int   acc;
        int   q;
        exp_t e;
        logic [31:0] cw;
        cw       = coef;
        in_valid = 1'b1;
        in_coef  = cw[COEF_W-1:0];
        in_last  = last;
        tbl_sel  = tsel;
        guard    = 0;
        ok       = 1'b0;
        acc      = 0;
        while (!ok && guard < 200) begin
            @(negedge clk);
            if (in_ready) begin
                ok  = 1'b1;
                acc = cyc;
            end else begin
                guard++;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready low for %0d cycles, want acceptance", guard);
        end
        @(posedge clk);
        if (ok) begin
            if (m_idx == 0)
                m_tbl = tsel;
            q      = m_tbl ? LQ[m_idx] : CQ[m_idx];
            e.coef = exp_val(coef, q);
            e.idx  = 6'(m_idx);
            e.acc  = acc;
            e.lat  = lat_chk;
            sb.push_back(e);
            if (last && m_idx != 63)
                m_idx = 0;
            else
                m_idx = (m_idx + 1) % 64;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding, want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_coef !== 32'h0 || out_index !== 6'd0 ||
            out_last !== 1'b0 || blk_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b c=%h i=%0d l=%b e=%b r=%b, want v=0 c=0 i=0 l=0 e=0 r=1",
                     out_valid, out_coef, out_index, out_last, blk_err, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        lat_chk = 1'b1;
        send(3, 1'b0, 1'b1);
        send(-2, 1'b0, 1'b1);
        for (int i = 2; i < 64; i++)
            send(0, (i == 63), 1'b1);
        drain();
        lat_chk = 1'b0;
    endtask

    task automatic test_chroma_block();
        int start;
        lat_chk = 1'b1;
        start   = cyc;
        for (int i = 0; i < 64; i++)
            send(1, (i == 63), (i >= 32));
        drain();
        lat_chk = 1'b0;
        checks++;
        if (last_cons - start != 65) begin
            errors++;
            $display("FAIL block_cycles: got last output in cycle %0d, want 65", last_cons - start);
        end
        checks++;
        if (blk_err !== 1'b0) begin
            errors++;
            $display("FAIL chroma_blk_err: got %b, want 0", blk_err);
        end
    endtask

    task automatic test_saturation();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 63; i++)
                send(int'($urandom_range(0, 4095)) - 2048, 1'b0, 1'b1);
            send((b == 0) ? 2047 : -2048, 1'b1, 1'b1);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bit pat [4];
        bit sent_done;
        int base;
        pat       = '{1'b1, 1'b0, 1'b0, 1'b1};
        sent_done = 1'b0;
        base      = n_cons;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(int'($urandom_range(0, 4095)) - 2048, 1'b0, 1'b1);
                sent_done = 1'b1;
            end
            begin
                for (int k = 0; k < 200 && !(sent_done && sb.size() == 0); k++) begin
                    out_ready = pat[k % 4];
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (n_cons - base != 10) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs, want 10", n_cons - base);
        end
        for (int i = 10; i < 64; i++)
            send(5, (i == 63), 1'b1);
        drain();
    endtask

    task automatic test_framing();
        checks++;
        if (blk_err !== 1'b0) begin
            errors++;
            $display("FAIL pre_err: got %b, want 0", blk_err);
        end
        for (int i = 0; i < 5; i++)
            send(i + 1, 1'b0, 1'b1);
        send(-7, 1'b1, 1'b1);
        checks++;
        if (blk_err !== 1'b1) begin
            errors++;
            $display("FAIL early_last_err: got %b, want 1", blk_err);
        end
        // Resync beat lands at index 0 and latches chroma for its block.
        send(9, 1'b0, 1'b0);
        for (int i = 1; i < 64; i++)
            send(3, (i == 63), 1'b1);
        for (int i = 0; i < 64; i++)
            send(int'($urandom_range(0, 255)) - 128, (i == 63), 1'b1);
        drain();
        checks++;
        if (blk_err !== 1'b1) begin
            errors++;
            $display("FAIL sticky_err: got %b, want 1", blk_err);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(4, 1'b0, 1'b0);
        send(6, 1'b0, 1'b0);
        #2;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL inflight_valid: got %b, want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || blk_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b e=%b, want v=0 e=0", out_valid, blk_err);
        end
        sb.delete();
        m_idx = 0;
        m_tbl = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        send(7, 1'b0, 1'b1);
        lat_chk   = 1'b0;
        for (int i = 1; i < 63; i++)
            send(-1, 1'b0, 1'b1);
        checks++;
        if (blk_err !== 1'b0) begin
            errors++;
            $display("FAIL pre63_err: got %b, want 0", blk_err);
        end
        send(2, 1'b0, 1'b1);
        checks++;
        if (blk_err !== 1'b1) begin
            errors++;
            $display("FAIL missing_last_err: got %b, want 1", blk_err);
        end
        send(1, 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chroma_block();
        test_saturation();
        test_backpressure();
        test_framing();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
